// File: rtl/pipelined_addsub.sv
// pipelined_addsub: STAGES-deep carry-select adder/subtractor with valid/ready handshakes.
// Optional macro SATURATE_EN clamps the result on signed overflow in the final stage.
module pipelined_addsub #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             opcode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             c_out,
   output logic             overflow,
   output logic             zero,
   output logic             negative
);
   localparam int CW  = WIDTH / STAGES;
   localparam int RS  = (STAGES > 1) ? STAGES - 1 : 1;
   localparam int MSB = WIDTH - 1;
   localparam logic [WIDTH-1:0] CMASK = WIDTH'({CW{1'b1}});

   // Inter-stage registers; index k holds the output of stage k.
   logic [WIDTH-1:0] r_a_p   [RS];
   logic [WIDTH-1:0] r_b_p   [RS];
   logic [WIDTH-1:0] r_sum_p [RS];
   logic             r_cy_p  [RS];
   logic             r_op_p  [RS];
   logic             r_vld_p [RS];

   // Per-stage inputs, taken from the ports for stage 0 and from the previous stage otherwise.
   logic [WIDTH-1:0] w_a_p   [STAGES];
   logic [WIDTH-1:0] w_b_p   [STAGES];
   logic [WIDTH-1:0] w_s_p   [STAGES];
   logic             w_ci_p  [STAGES];
   logic             w_op_p  [STAGES];
   logic             w_v_p   [STAGES];

   logic [WIDTH-1:0] r_result;
   logic             r_out_vld, r_cout, r_ovf, r_zero, r_neg;
   logic             w_advance;

`ifdef SATURATE_EN
   function automatic logic [WIDTH-1:0] f_saturate(input logic [WIDTH-1:0] sum,
                                                   input logic             ovf,
                                                   input logic             neg_ovf);
      if (!ovf) return sum;
      return neg_ovf ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
   endfunction
`endif

   assign w_advance = !r_out_vld || out_ready;
   assign in_ready  = w_advance;

   genvar k;
   generate
      for (k = 0; k < STAGES; k++) begin : g_stage
         logic [WIDTH-1:0] w_sum;
         logic [CW-1:0]    w_ac, w_bc, w_s0, w_s1;
         logic             w_c0, w_c1, w_co;

         if (k == 0) begin : g_in
            // Subtract is a + ~b + 1, so the inversion and carry-in enter here.
            assign w_a_p[k]  = a;
            assign w_b_p[k]  = opcode ? b : ~b;
            assign w_s_p[k]  = '0;
            assign w_ci_p[k] = ~opcode;
            assign w_op_p[k] = opcode;
            assign w_v_p[k]  = in_valid;
         end else begin : g_skew
            assign w_a_p[k]  = r_a_p[k-1];
            assign w_b_p[k]  = r_b_p[k-1];
            assign w_s_p[k]  = r_sum_p[k-1];
            assign w_ci_p[k] = r_cy_p[k-1];
            assign w_op_p[k] = r_op_p[k-1];
            assign w_v_p[k]  = r_vld_p[k-1];
         end

         assign w_ac = w_a_p[k][k*CW +: CW];
         assign w_bc = w_b_p[k][k*CW +: CW];
         assign {w_c0, w_s0} = {1'b0, w_ac} + {1'b0, w_bc};
         assign {w_c1, w_s1} = {1'b0, w_ac} + {1'b0, w_bc} + (CW+1)'(1);
         assign w_co  = w_ci_p[k] ? w_c1 : w_c0;
         assign w_sum = (w_s_p[k] & ~(CMASK << (k*CW)))
                      | (WIDTH'(w_ci_p[k] ? w_s1 : w_s0) << (k*CW));

         if (k == STAGES-1) begin : g_out
            logic             w_ovf;
            logic [WIDTH-1:0] w_res;

            assign w_ovf = (w_a_p[k][MSB] == w_b_p[k][MSB]) && (w_sum[MSB] != w_a_p[k][MSB]);
`ifdef SATURATE_EN
            assign w_res = f_saturate(w_sum, w_ovf, w_a_p[k][MSB]);
`else
            assign w_res = w_sum;
`endif
            // Final stage: flags from the fully assembled result; fields only load on valid data.
            always_ff @(posedge clk) begin
               if (reset) begin
                  r_out_vld <= 1'b0;
                  r_result  <= '0;
                  r_cout    <= 1'b0;
                  r_ovf     <= 1'b0;
                  r_zero    <= 1'b0;
                  r_neg     <= 1'b0;
               end else if (w_advance) begin
                  r_out_vld <= w_v_p[k];
                  if (w_v_p[k]) begin
                     r_result <= w_res;
                     r_cout   <= w_co ^ ~w_op_p[k];
                     r_ovf    <= w_ovf;
                     r_zero   <= (w_res == '0);
                     r_neg    <= w_res[MSB];
                  end
               end
            end
         end else begin : g_reg
            // Stage k boundary: selected chunk, carry and skewed operands move on together.
            always_ff @(posedge clk) begin
               if (reset)          r_vld_p[k] <= 1'b0;
               else if (w_advance) r_vld_p[k] <= w_v_p[k];
            end

            always_ff @(posedge clk) begin
               if (w_advance) begin
                  r_a_p[k]   <= w_a_p[k];
                  r_b_p[k]   <= w_b_p[k];
                  r_sum_p[k] <= w_sum;
                  r_cy_p[k]  <= w_co;
                  r_op_p[k]  <= w_op_p[k];
               end
            end
         end
      end
   endgenerate

   assign out_valid = r_out_vld;
   assign result    = r_result;
   assign c_out     = r_cout;
   assign overflow  = r_ovf;
   assign zero      = r_zero;
   assign negative  = r_neg;
endmodule

// File: tb/tb_pipelined_addsub.sv
// Directed and randomised bench for pipelined_addsub at STAGES=4 (main), 1 and 8.
// Define SATURATE_EN for both RTL and bench to exercise the clamp.
module tb_pipelined_addsub;
   typedef struct {
      logic [35:0] v;
      int          c;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset, in_valid, opcode, out_ready;
   logic [31:0] a, b;

   logic        ov  [3];
   logic        ir  [3];
   logic [31:0] res [3];
   logic        co  [3], of [3], ze [3], ng [3];

   int          n_total = 0, n_pass = 0, n_fail = 0;
   int          stg [3] = '{4, 1, 8};
   string       nm  [3] = '{"s4", "s1", "s8"};
   exp_t        q   [3][$];

   logic [31:0] sa [8], sb [8];
   logic        sop [8];
   logic [35:0] held;
   int          nissue, nrecv, last_cyc, nseen, lat, nacc, cyc;
   exp_t        e;

   always #5 clk = ~clk;

   pipelined_addsub #(.WIDTH(32), .STAGES(4)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[0]), .a(a), .b(b),
      .opcode(opcode), .out_valid(ov[0]), .out_ready(out_ready), .result(res[0]),
      .c_out(co[0]), .overflow(of[0]), .zero(ze[0]), .negative(ng[0]));

   pipelined_addsub #(.WIDTH(32), .STAGES(1)) dut_s1 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[1]), .a(a), .b(b),
      .opcode(opcode), .out_valid(ov[1]), .out_ready(out_ready), .result(res[1]),
      .c_out(co[1]), .overflow(of[1]), .zero(ze[1]), .negative(ng[1]));

   pipelined_addsub #(.WIDTH(32), .STAGES(8)) dut_s8 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[2]), .a(a), .b(b),
      .opcode(opcode), .out_valid(ov[2]), .out_ready(out_ready), .result(res[2]),
      .c_out(co[2]), .overflow(of[2]), .zero(ze[2]), .negative(ng[2]));

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [35:0] fields(input int i);
      return {res[i], co[i], of[i], ze[i], ng[i]};
   endfunction

   function automatic logic [35:0] f(input logic [31:0] r, input logic c, v, z, n);
      return {r, c, v, z, n};
   endfunction

   // Reference: exact signed result decides overflow, unsigned compare decides borrow.
   function automatic logic [35:0] model(input logic [31:0] x, y, input logic add);
      logic [32:0] u;
      longint      s;
      logic [31:0] r;
      logic        c, v;
      if (add) begin
         u = {1'b0, x} + {1'b0, y};
         c = u[32];
         s = longint'($signed(x)) + longint'($signed(y));
      end else begin
         u = {1'b0, x} - {1'b0, y};
         c = (x < y);
         s = longint'($signed(x)) - longint'($signed(y));
      end
      r = u[31:0];
      v = (s != longint'($signed(r)));
`ifdef SATURATE_EN
      if (v) r = (s < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
      return {r, c, v, (r == 32'h0), r[31]};
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0:       return 32'h0000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   task automatic run_op(input string tag, input logic [31:0] ia, ib, input logic iop,
                         input logic [35:0] expv);
      int l;
      @(negedge clk);
      a = ia; b = ib; opcode = iop; in_valid = 1'b1;
      #1 check({tag, "_rdy"}, 64'(ir[0]), 64'd1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0; a = $urandom; b = $urandom; opcode = 1'b0;
      l = 1;
      while (!ov[0] && l < 20) begin
         @(negedge clk);
         l++;
      end
      check({tag, "_lat"}, 64'(l), 64'd4);
      check(tag, 64'(fields(0)), 64'(expv));
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; opcode = 1'b0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         check({"reset_valid_", nm[i]}, 64'(ov[i]), 64'd0);
         check({"reset_fields_", nm[i]}, 64'(fields(i)), 64'd0);
      end
      check("reset_in_ready", 64'(ir[0]), 64'd1);
      reset = 1'b0;

      run_op("add_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, f(32'h0, 1, 0, 1, 0));
`ifdef SATURATE_EN
      run_op("sub_ovf", 32'h8000_0000, 32'h0000_0001, 1'b0, f(32'h8000_0000, 0, 1, 0, 1));
      run_op("add_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b1, f(32'h7FFF_FFFF, 0, 1, 0, 0));
      run_op("add_negovf", 32'h8000_0000, 32'h8000_0000, 1'b1, f(32'h8000_0000, 1, 1, 0, 1));
`else
      run_op("sub_ovf", 32'h8000_0000, 32'h0000_0001, 1'b0, f(32'h7FFF_FFFF, 0, 1, 0, 0));
      run_op("add_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b1, f(32'h8000_0000, 0, 1, 0, 1));
      run_op("add_negovf", 32'h8000_0000, 32'h8000_0000, 1'b1, f(32'h0, 1, 1, 1, 0));
`endif
      run_op("sub_borrow", 32'h0000_0003, 32'h0000_0005, 1'b0, f(32'hFFFF_FFFE, 1, 0, 0, 1));
      run_op("sub_equal", 32'h0000_0005, 32'h0000_0005, 1'b0, f(32'h0, 0, 0, 1, 0));
      run_op("sub_zero_one", 32'h0000_0000, 32'h0000_0001, 1'b0, f(32'hFFFF_FFFF, 1, 0, 0, 1));
      run_op("add_plain", 32'h1234_5678, 32'h1111_1111, 1'b1, f(32'h2345_6789, 0, 0, 0, 0));
      run_op("add_chunk_carry", 32'h00FF_FFFF, 32'h0000_0001, 1'b1, f(32'h0100_0000, 0, 0, 0, 0));

      // Back-to-back stream with a three-cycle downstream stall.
      for (int i = 0; i < 8; i++) begin
         sa[i] = pick(); sb[i] = pick(); sop[i] = i[0];
      end
      nissue = 0; nrecv = 0; last_cyc = -1;
      for (int c = 0; c < 40 && nrecv < 8; c++) begin
         @(negedge clk);
         out_ready = !(c >= 6 && c < 9);
         in_valid  = (nissue < 8);
         if (nissue < 8) begin
            a = sa[nissue]; b = sb[nissue]; opcode = sop[nissue];
         end
         #1;
         if (ov[0] && out_ready) begin
            check("stream_data", 64'(fields(0)), 64'(model(sa[nrecv], sb[nrecv], sop[nrecv])));
            nrecv++;
            last_cyc = c;
         end
         if (!out_ready) begin
            check("stall_valid", 64'(ov[0]), 64'd1);
            check("stall_in_ready", 64'(ir[0]), 64'd0);
            if (c == 6) held = fields(0);
            else        check("stall_hold", 64'(fields(0)), 64'(held));
         end
         if (in_valid && ir[0]) nissue++;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      check("stream_count", 64'(nrecv), 64'd8);
      check("stream_last_cycle", 64'(last_cyc), 64'd14);

      // Reset with three operations in flight, then a fresh operation.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         in_valid = 1'b1; a = 32'h0000_1000 * (i + 1); b = 32'h1; opcode = 1'b1;
      end
      @(negedge clk);
      in_valid = 1'b0; reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("flush_valid", 64'(ov[0]), 64'd0);
      check("flush_fields", 64'(fields(0)), 64'd0);
      a = 32'h0000_0010; b = 32'h0000_0003; opcode = 1'b0; in_valid = 1'b1;
      #1 check("flush_in_ready", 64'(ir[0]), 64'd1);
      nseen = 0; lat = 0;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         in_valid = 1'b0;
         if (ov[0]) begin
            nseen++;
            lat = c;
            check("fresh_data", 64'(fields(0)), 64'(f(32'h0000_000D, 0, 0, 0, 0)));
         end
      end
      check("fresh_count", 64'(nseen), 64'd1);
      check("fresh_latency", 64'(lat), 64'd4);

      // Random traffic into all three depths against the reference model.
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      nacc = 0; cyc = 0;
      while ((nacc < 1000 || q[0].size() + q[1].size() + q[2].size() != 0) && cyc < 3000) begin
         @(negedge clk);
         for (int i = 0; i < 3; i++) begin
            if (ov[i]) begin
               if (q[i].size() == 0) begin
                  check({"rnd_spurious_", nm[i]}, 64'(ov[i]), 64'd0);
               end else begin
                  e = q[i].pop_front();
                  check({"rnd_data_", nm[i]}, 64'(fields(i)), 64'(e.v));
                  check({"rnd_lat_", nm[i]}, 64'(cyc - e.c), 64'(stg[i]));
               end
            end
         end
         if (nacc < 1000) begin
            in_valid = ($urandom_range(0, 7) != 0);
            a = pick(); b = pick(); opcode = 1'($urandom_range(0, 1));
            #1;
            if (in_valid) begin
               for (int i = 0; i < 3; i++)
                  if (ir[i]) q[i].push_back('{model(a, b, opcode), cyc});
               nacc++;
            end
         end else begin
            in_valid = 1'b0;
         end
         cyc++;
      end
      for (int i = 0; i < 3; i++)
         check({"rnd_drained_", nm[i]}, 64'(q[i].size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
